// File: rtl/serial_addr_decoder_pkg.sv
// Shared serial-bus types: decoder FSM state encoding and a width helper.
// Also imported by the bus arbiter.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2,
        SELECT = 2'd3
    } dec_state_t;

    // Bits needed to represent the values 0..n-1 (never less than one).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addr_decoder_if.sv
// Serial-bus signals between the arbiter/bus mux (master) and the address decoder (slave).
// ERR_CNT exists only when ADDR_ERR_CNT_EN is defined.
interface serial_addr_decoder_if #(
    parameter int NUM_SLAVES = 3
);
    logic                  B_UTIL;
    logic                  A_ADD;
    logic                  B_BUS_OUT;
    logic [NUM_SLAVES-1:0] B_SBSY;
    logic [NUM_SLAVES-1:0] AD_SEL;
    logic [NUM_SLAVES-1:0] SPL_SEL;
    logic                  ADDR_ERR;
    logic                  DEC_DONE;
`ifdef ADDR_ERR_CNT_EN
    logic [7:0]            ERR_CNT;
`endif

    modport master (
        output B_UTIL, A_ADD, B_BUS_OUT, B_SBSY,
        input  AD_SEL, SPL_SEL, ADDR_ERR, DEC_DONE
`ifdef ADDR_ERR_CNT_EN
        , input ERR_CNT
`endif
    );

    modport slave (
        input  B_UTIL, A_ADD, B_BUS_OUT, B_SBSY,
        output AD_SEL, SPL_SEL, ADDR_ERR, DEC_DONE
`ifdef ADDR_ERR_CNT_EN
        , output ERR_CNT
`endif
    );

endinterface

// File: rtl/serial_addr_decoder_addr_shift_reg.sv
// MSB-first serial-in shift register for the device id with a saturating bit counter.
// clr together with en loads din as the first bit of a new phase.
module addr_shift_reg
    import serial_bus_pkg::*;
#(
    parameter int DEV_BITS = 2
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                clr,
    input  logic                en,
    input  logic                din,
    output logic [DEV_BITS-1:0] id,
    output logic                cnt_full
);
    localparam int CW = id_width(DEV_BITS + 1);

    logic [CW-1:0] cnt;

    assign cnt_full = (cnt == CW'(DEV_BITS));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            id  <= '0;
            cnt <= '0;
        end else if (clr) begin
            id  <= en ? DEV_BITS'(din) : '0;
            cnt <= en ? CW'(1) : '0;
        end else if (en && !cnt_full) begin
            id  <= DEV_BITS'({id, din});
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_addr_decoder.sv
// Serial slave-address decoder: FSM, one-hot select, split-pending flags.
// Define ADDR_ERR_CNT_EN to add the saturating ERR_CNT address-error counter.
module serial_addr_decoder
    import serial_bus_pkg::*;
#(
    parameter int                    NUM_SLAVES = 3,
    parameter int                    DEV_BITS   = 2,
    parameter logic [NUM_SLAVES-1:0] SPLIT_MASK = 3'b100
) (
    input logic                  CLK,
    input logic                  RSTN,
    serial_addr_decoder_if.slave bus
);
    dec_state_t state, state_nxt;

    logic [DEV_BITS-1:0]   id;
    logic                  cnt_full;
    logic                  sr_clr, sr_en;
    logic [NUM_SLAVES-1:0] id_hot, split_set;
    logic                  dec_err, dec_split;
    logic [NUM_SLAVES-1:0] ad_sel_d, spl_sel_d;
    logic                  addr_err_d, dec_done_d;

    addr_shift_reg #(.DEV_BITS(DEV_BITS)) u_shift (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .clr      (sr_clr),
        .en       (sr_en),
        .din      (bus.B_BUS_OUT),
        .id       (id),
        .cnt_full (cnt_full)
    );

    always_ff @(posedge CLK) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!bus.B_UTIL) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.A_ADD)  state_nxt = SHIFT;
                SHIFT:   if (!bus.A_ADD) state_nxt = DECODE;
                DECODE:  state_nxt = (dec_err || dec_split) ? IDLE : SELECT;
                SELECT:  if (bus.A_ADD)  state_nxt = SHIFT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Decode of the captured id; only meaningful while in DECODE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        id_hot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) id_hot[i] = (int'(id) == i);
        dec_err   = !cnt_full || (int'(id) >= NUM_SLAVES);
        split_set = (bus.B_UTIL && state == DECODE && !dec_err)
                    ? (id_hot & SPLIT_MASK & bus.B_SBSY) : '0;
        dec_split = |split_set;
    end

    always_comb begin
        sr_clr     = !bus.B_UTIL || (bus.A_ADD && (state == IDLE || state == SELECT));
        sr_en      = bus.B_UTIL && bus.A_ADD && (state != DECODE);
        ad_sel_d   = bus.AD_SEL;
        addr_err_d = 1'b0;
        dec_done_d = 1'b0;
        spl_sel_d  = split_set | (bus.SPL_SEL & bus.B_SBSY);
        if (!bus.B_UTIL) begin
            ad_sel_d = '0;
        end else if (state == DECODE) begin
            dec_done_d = 1'b1;
            addr_err_d = dec_err;
            ad_sel_d   = (dec_err || dec_split) ? '0 : id_hot;
        end else if (state == SELECT && bus.A_ADD) begin
            ad_sel_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            bus.AD_SEL   <= '0;
            bus.SPL_SEL  <= '0;
            bus.ADDR_ERR <= 1'b0;
            bus.DEC_DONE <= 1'b0;
        end else begin
            bus.AD_SEL   <= ad_sel_d;
            bus.SPL_SEL  <= spl_sel_d;
            bus.ADDR_ERR <= addr_err_d;
            bus.DEC_DONE <= dec_done_d;
        end
    end

`ifdef ADDR_ERR_CNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge CLK) begin
        if (!RSTN)                              err_cnt <= '0;
        else if (addr_err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

    assign bus.ERR_CNT = err_cnt;
`endif

endmodule

// File: tb/tb_serial_addr_decoder.sv
// Directed plus random bench for serial_addr_decoder against an address-phase level model.
module tb_serial_addr_decoder;
    localparam int             NS   = 3;
    localparam int             DB   = 2;
    localparam logic [NS-1:0]  MASK = 3'b100;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    serial_addr_decoder_if #(.NUM_SLAVES(NS)) bus ();

    serial_addr_decoder #(.NUM_SLAVES(NS), .DEV_BITS(DB), .SPLIT_MASK(MASK)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: phase-level view of the bus (collecting bits, decode pending, selection).
    bit          m_collect, m_pending;
    bit          q[$];
    logic [NS-1:0] m_sel, m_spl;
    bit          m_done, m_err;
    int          m_errcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rstn, util, add, din, input logic [NS-1:0] sbsy);
        int id;
        m_done = 0;
        m_err  = 0;
        if (!rstn) begin
            m_collect = 0; m_pending = 0; q.delete();
            m_sel = '0; m_spl = '0; m_errcnt = 0;
            return;
        end
        m_spl = m_spl & sbsy;
        if (!util) begin
            m_collect = 0; m_pending = 0; q.delete(); m_sel = '0;
        end else if (m_pending) begin
            m_pending = 0;
            m_done    = 1;
            id = 0;
            for (int k = 0; k < DB && k < q.size(); k++) id = id * 2 + int'(q[k]);
            if (q.size() < DB || id >= NS) begin
                m_err = 1;
                m_sel = '0;
                if (m_errcnt < 255) m_errcnt++;
            end else if (MASK[id] && sbsy[id]) begin
                m_spl[id] = 1'b1;
                m_sel     = '0;
            end else begin
                m_sel = NS'(1 << id);
            end
        end else if (m_collect) begin
            if (add) q.push_back(din);
            else begin m_collect = 0; m_pending = 1; end
        end else if (add) begin
            m_sel = '0;
            q.delete();
            q.push_back(din);
            m_collect = 1;
        end
    endtask

    task automatic step(input logic rstn, util, add, din, input logic [NS-1:0] sbsy);
        RSTN          = rstn;
        bus.B_UTIL    = util;
        bus.A_ADD     = add;
        bus.B_BUS_OUT = din;
        bus.B_SBSY    = sbsy;
        @(posedge CLK);
        model_edge(rstn, util, add, din, sbsy);
        #1;
        check("AD_SEL",   32'(bus.AD_SEL),   32'(m_sel));
        check("SPL_SEL",  32'(bus.SPL_SEL),  32'(m_spl));
        check("ADDR_ERR", 32'(bus.ADDR_ERR), 32'(m_err));
        check("DEC_DONE", 32'(bus.DEC_DONE), 32'(m_done));
        check("onehot0",  32'($countones(bus.AD_SEL) <= 1), 32'(1));
        check("disjoint", 32'(bus.AD_SEL & bus.SPL_SEL), 32'(0));
`ifdef ADDR_ERR_CNT_EN
        check("ERR_CNT",  32'(bus.ERR_CNT),  32'(m_errcnt));
`endif
    endtask

    // n address bits MSB-first, then A_ADD low through the decode exit edge.
    task automatic addr(input int n, input logic [7:0] v, input logic [NS-1:0] sbsy);
        for (int k = n - 1; k >= 0; k--) step(1, 1, 1, v[k], sbsy);
        step(1, 1, 0, 0, sbsy);
        step(1, 1, 0, 0, sbsy);
    endtask

    initial begin
        step(0, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        check("reset_state", 32'(dut.state), 32'(serial_bus_pkg::IDLE));

        addr(2, 8'b10, 3'b000);
        check("sel_slave2", 32'(bus.AD_SEL), 32'(3'b100));
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);
        step(1, 0, 0, 0, '0);

        addr(2, 8'b10, 3'b000);
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        check("reset_mid_select", 32'(dut.state), 32'(serial_bus_pkg::IDLE));

        addr(4, 8'b0110, 3'b000);
        check("extra_bits_ignored", 32'(bus.AD_SEL), 32'(3'b010));
        step(1, 0, 0, 0, '0);

        addr(2, 8'b11, 3'b000);
        step(1, 1, 0, 0, '0);
        addr(1, 8'b1, 3'b000);
        step(1, 1, 0, 0, '0);

        addr(2, 8'b10, 3'b100);
        check("split_pending", 32'(bus.SPL_SEL), 32'(3'b100));
        addr(2, 8'b01, 3'b100);
        check("sel_during_split", 32'(bus.AD_SEL), 32'(3'b010));
        step(1, 1, 0, 0, 3'b000);

        addr(2, 8'b00, 3'b000);
        addr(2, 8'b01, 3'b000);
        step(1, 1, 1, 1, '0);
        step(1, 0, 1, 0, '0);
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);

`ifdef ADDR_ERR_CNT_EN
        for (int i = 0; i < 260; i++) addr(2, 8'b11, 3'b000);
        check("err_cnt_sat", 32'(bus.ERR_CNT), 32'(8'hFF));
`endif

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(99) < 90) ? 1'b1 : 1'b0,
                 1'($urandom), 1'($urandom),
                 ($urandom_range(3) == 0) ? NS'($urandom) : NS'(3'b100));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
